// File: rtl/sp_mem_arb_pkg.sv
// Shared types and constants for the two-requester single-port SRAM arbiter.
// Optional stall counters are enabled with SP_MEM_ARB_PERF_EN (see sp_mem_arbiter).
package sp_mem_arb_pkg;

   localparam int NUM_REQ     = 2;
   localparam int SP_ADDR_W   = 10;
   localparam int SP_DATA_W   = 64;
   localparam int SP_BE_W     = SP_DATA_W / 8;
   localparam int BURST_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

   typedef struct packed {
      logic                 we;
      logic [SP_ADDR_W-1:0] addr;
      logic [SP_BE_W-1:0]   be;
      logic [SP_DATA_W-1:0] wdata;
   } req_t;

   // Burst length grows by one per kept grant and sticks at the limit.
   function automatic logic [BURST_CNT_W-1:0] burst_inc(input logic [BURST_CNT_W-1:0] cnt,
                                                        input logic [BURST_CNT_W-1:0] lim);
      return (cnt < lim) ? cnt + 1'b1 : lim;
   endfunction

endpackage

// File: rtl/sp_mem_arb_perf_cnt.sv
// Saturating event counter with a synchronous clear that wins over increment.
// Instantiated by sp_mem_arbiter only when SP_MEM_ARB_PERF_EN is defined.
module sp_mem_arb_perf_cnt #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sp_mem_arbiter.sv
// Two-requester arbiter for one single-port SRAM: ownership with burst-limited hold,
// 1-cycle read return tagged with the owner. SP_MEM_ARB_PERF_EN adds stall counters.
module sp_mem_arbiter
   import sp_mem_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 64,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int MAX_BURST  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req_i,
   input  logic                  m0_we_i,
   input  logic [ADDR_WIDTH-1:0] m0_addr_i,
   input  logic [BE_WIDTH-1:0]   m0_be_i,
   input  logic [DATA_WIDTH-1:0] m0_wdata_i,
   output logic                  m0_gnt_o,
   output logic                  m0_rvalid_o,
   output logic [DATA_WIDTH-1:0] m0_rdata_o,
   input  logic                  m1_req_i,
   input  logic                  m1_we_i,
   input  logic [ADDR_WIDTH-1:0] m1_addr_i,
   input  logic [BE_WIDTH-1:0]   m1_be_i,
   input  logic [DATA_WIDTH-1:0] m1_wdata_i,
   output logic                  m1_gnt_o,
   output logic                  m1_rvalid_o,
   output logic [DATA_WIDTH-1:0] m1_rdata_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [BE_WIDTH-1:0]   mem_be_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   output arb_state_e            dbg_state_o
`ifdef SP_MEM_ARB_PERF_EN
   ,
   input  logic                  perf_clr_i,
   output logic [31:0]           m0_stall_cnt_o,
   output logic [31:0]           m1_stall_cnt_o
`endif
);

   // Handshake: a requester holds req and payload until its gnt is seen high in the
   // same cycle; a granted read returns rvalid with rdata exactly one cycle later.

   localparam int                     OWNER_W = $clog2(NUM_REQ);
   localparam logic [BURST_CNT_W-1:0] MAX_B   = BURST_CNT_W'(MAX_BURST);

   arb_state_e             state_q, state_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   rd_pend_q, rd_pend_d;
   logic [OWNER_W-1:0]     rd_owner_q, rd_owner_d;
   logic                   gnt0, gnt1;

   // Reset masks grants so nothing reaches the SRAM while rst_n is low.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         case (state_q)
            OWN0: begin
               if (m0_req_i && (!m1_req_i || (burst_cnt_q < MAX_B))) gnt0 = 1'b1;
               else                                                   gnt1 = m1_req_i;
            end
            OWN1: begin
               if (m1_req_i && (!m0_req_i || (burst_cnt_q < MAX_B))) gnt1 = 1'b1;
               else                                                   gnt0 = m0_req_i;
            end
            default: begin
               if (m0_req_i) gnt0 = 1'b1;
               else          gnt1 = m1_req_i;
            end
         endcase
      end
   end

   always_comb begin
      state_d     = IDLE;
      burst_cnt_d = '0;
      if (gnt0) begin
         state_d     = OWN0;
         burst_cnt_d = (state_q == OWN0) ? burst_inc(burst_cnt_q, MAX_B) : BURST_CNT_W'(1);
      end else if (gnt1) begin
         state_d     = OWN1;
         burst_cnt_d = (state_q == OWN1) ? burst_inc(burst_cnt_q, MAX_B) : BURST_CNT_W'(1);
      end
      rd_pend_d  = (gnt0 | gnt1) & ~mem_we_o;
      rd_owner_d = OWNER_W'(gnt1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         rd_pend_q   <= 1'b0;
         rd_owner_q  <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rd_pend_q   <= rd_pend_d;
         rd_owner_q  <= rd_owner_d;
      end
   end

   assign m0_gnt_o    = gnt0;
   assign m1_gnt_o    = gnt1;
   assign mem_req_o   = gnt0 | gnt1;
   assign mem_we_o    = gnt1 ? m1_we_i    : m0_we_i;
   assign mem_addr_o  = gnt1 ? m1_addr_i  : m0_addr_i;
   assign mem_be_o    = gnt1 ? m1_be_i    : m0_be_i;
   assign mem_wdata_o = gnt1 ? m1_wdata_i : m0_wdata_i;

   assign m0_rvalid_o = rst_n & rd_pend_q & (rd_owner_q == OWNER_W'(0));
   assign m1_rvalid_o = rst_n & rd_pend_q & (rd_owner_q == OWNER_W'(1));
   assign m0_rdata_o  = mem_rdata_i;
   assign m1_rdata_o  = mem_rdata_i;
   assign dbg_state_o = state_q;

`ifdef SP_MEM_ARB_PERF_EN
   sp_mem_arb_perf_cnt #(.WIDTH(32)) u_m0_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (perf_clr_i),
      .inc_i (m0_req_i & ~gnt0),
      .cnt_o (m0_stall_cnt_o)
   );

   sp_mem_arb_perf_cnt #(.WIDTH(32)) u_m1_stall (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (perf_clr_i),
      .inc_i (m1_req_i & ~gnt1),
      .cnt_o (m1_stall_cnt_o)
   );
`endif

endmodule

// File: tb/tb_sp_mem_arbiter.sv
// Bench for sp_mem_arbiter: directed scenarios then random traffic against an
// owner/streak reference model and a reference memory. Honours SP_MEM_ARB_PERF_EN.
module tb_sp_mem_arbiter;
   import sp_mem_arb_pkg::*;

   localparam int AW   = SP_ADDR_W;
   localparam int DW   = SP_DATA_W;
   localparam int BW   = SP_BE_W;
   localparam int MAXB = 8;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          m0_req_i = 1'b0, m0_we_i = 1'b0;
   logic [AW-1:0] m0_addr_i = '0;
   logic [BW-1:0] m0_be_i = '0;
   logic [DW-1:0] m0_wdata_i = '0;
   logic          m1_req_i = 1'b0, m1_we_i = 1'b0;
   logic [AW-1:0] m1_addr_i = '0;
   logic [BW-1:0] m1_be_i = '0;
   logic [DW-1:0] m1_wdata_i = '0;
   logic          m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
   logic [DW-1:0] m0_rdata_o, m1_rdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [BW-1:0] mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i = '0;
   arb_state_e    dbg_state_o;
`ifdef SP_MEM_ARB_PERF_EN
   logic          perf_clr_i = 1'b0;
   logic [31:0]   m0_stall_cnt_o, m1_stall_cnt_o;
`endif

   sp_mem_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .BE_WIDTH   (BW),
      .MAX_BURST  (MAXB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0_req_i    (m0_req_i),
      .m0_we_i     (m0_we_i),
      .m0_addr_i   (m0_addr_i),
      .m0_be_i     (m0_be_i),
      .m0_wdata_i  (m0_wdata_i),
      .m0_gnt_o    (m0_gnt_o),
      .m0_rvalid_o (m0_rvalid_o),
      .m0_rdata_o  (m0_rdata_o),
      .m1_req_i    (m1_req_i),
      .m1_we_i     (m1_we_i),
      .m1_addr_i   (m1_addr_i),
      .m1_be_i     (m1_be_i),
      .m1_wdata_i  (m1_wdata_i),
      .m1_gnt_o    (m1_gnt_o),
      .m1_rvalid_o (m1_rvalid_o),
      .m1_rdata_o  (m1_rdata_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .dbg_state_o (dbg_state_o)
`ifdef SP_MEM_ARB_PERF_EN
      ,
      .perf_clr_i     (perf_clr_i),
      .m0_stall_cnt_o (m0_stall_cnt_o),
      .m1_stall_cnt_o (m1_stall_cnt_o)
`endif
   );

   // SRAM macro environment: byte-masked write, registered read.
   logic [DW-1:0] sram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_req_o) begin
         if (mem_we_o) begin
            for (int b = 0; b < BW; b++)
               if (mem_be_o[b]) sram[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
         end else begin
            mem_rdata_i <= sram[mem_addr_o];
         end
      end
   end

   // ---------------- reference model / scoreboard ----------------
   int            vectors = 0;
   int            fails   = 0;
   int            owner   = -1;
   int            streak  = 0;
   bit            rd_pend_m = 1'b0;
   int            rd_own_m  = 0;
   bit            started   = 1'b0;
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] exp_q[$];
   int unsigned   stall_m [2];
   bit            p_req [2];
   req_t          p_tx  [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Owner keeps the port unless it went quiet, or it has used its whole burst
   // while the other requester waits; from idle requester 0 wins ties.
   function automatic int pick(input bit r0, input bit r1);
      bit r [2];
      r[0] = r0;
      r[1] = r1;
      if (!r0 && !r1) return -1;
      if (owner < 0) return r0 ? 0 : 1;
      if (r[owner] && (!r[1-owner] || streak < MAXB)) return owner;
      return 1 - owner;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic arm(input int x, input bit we, input logic [AW-1:0] addr,
                      input logic [BW-1:0] be, input logic [DW-1:0] wdata);
      p_req[x]      = 1'b1;
      p_tx[x].we    = we;
      p_tx[x].addr  = addr;
      p_tx[x].be    = be;
      p_tx[x].wdata = wdata;
   endtask

   task automatic step(input bit rst_in, input bit clr_in);
      int            g;
      logic [DW-1:0] d;
      bit            rv_exp [2];
      arb_state_e    st_exp;
      @(negedge clk);
      rst_n      = rst_in;
      m0_req_i   = p_req[0];
      m0_we_i    = p_tx[0].we;
      m0_addr_i  = p_tx[0].addr;
      m0_be_i    = p_tx[0].be;
      m0_wdata_i = p_tx[0].wdata;
      m1_req_i   = p_req[1];
      m1_we_i    = p_tx[1].we;
      m1_addr_i  = p_tx[1].addr;
      m1_be_i    = p_tx[1].be;
      m1_wdata_i = p_tx[1].wdata;
`ifdef SP_MEM_ARB_PERF_EN
      perf_clr_i = clr_in;
`endif
      #1;
      if (started) begin
         st_exp = (owner < 0) ? IDLE : ((owner == 0) ? OWN0 : OWN1);
         chk("state", 64'(dbg_state_o), 64'(st_exp));
`ifdef SP_MEM_ARB_PERF_EN
         chk("m0_stall", 64'(m0_stall_cnt_o), 64'(stall_m[0]));
         chk("m1_stall", 64'(m1_stall_cnt_o), 64'(stall_m[1]));
`endif
      end
      for (int x = 0; x < 2; x++) rv_exp[x] = rst_in && rd_pend_m && (rd_own_m == x);
      chk("m0_rvalid", 64'(m0_rvalid_o), 64'(rv_exp[0]));
      chk("m1_rvalid", 64'(m1_rvalid_o), 64'(rv_exp[1]));
      if (rd_pend_m) begin
         d = exp_q.pop_front();
         if (rv_exp[0]) chk("m0_rdata", m0_rdata_o, d);
         if (rv_exp[1]) chk("m1_rdata", m1_rdata_o, d);
      end
      g = rst_in ? pick(p_req[0], p_req[1]) : -1;
      chk("m0_gnt", 64'(m0_gnt_o), 64'(g == 0));
      chk("m1_gnt", 64'(m1_gnt_o), 64'(g == 1));
      chk("mem_req", 64'(mem_req_o), 64'(g >= 0));
      if (g >= 0) begin
         chk("mem_we", 64'(mem_we_o), 64'(p_tx[g].we));
         chk("mem_addr", 64'(mem_addr_o), 64'(p_tx[g].addr));
         chk("mem_be", 64'(mem_be_o), 64'(p_tx[g].be));
         if (p_tx[g].we) chk("mem_wdata", mem_wdata_o, p_tx[g].wdata);
      end
      // advance the model across the coming clock edge
      if (!rst_in || clr_in) begin
         stall_m[0] = 0;
         stall_m[1] = 0;
      end else begin
         for (int x = 0; x < 2; x++)
            if (p_req[x] && g != x && stall_m[x] != 32'hFFFF_FFFF) stall_m[x]++;
      end
      rd_pend_m = 1'b0;
      if (!rst_in) begin
         owner  = -1;
         streak = 0;
      end else if (g < 0) begin
         owner  = -1;
         streak = 0;
      end else begin
         if (g == owner) streak = (streak < MAXB) ? streak + 1 : MAXB;
         else begin
            owner  = g;
            streak = 1;
         end
         if (p_tx[g].we) begin
            for (int b = 0; b < BW; b++)
               if (p_tx[g].be[b]) ref_mem[p_tx[g].addr][b*8 +: 8] = p_tx[g].wdata[b*8 +: 8];
         end else begin
            exp_q.push_back(ref_mem[p_tx[g].addr]);
            rd_pend_m = 1'b1;
            rd_own_m  = g;
         end
         p_req[g] = 1'b0;
      end
      started = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      p_tx[0]  = '0;
      p_tx[1]  = '0;
      stall_m[0] = 0;
      stall_m[1] = 0;

      repeat (3) step(1'b0, 1'b0);
      chk("rst_state", 64'(dbg_state_o), 64'(IDLE));

      // preload the address window used below
      for (int a = 0; a < 32; a++) begin
         arm(0, 1'b1, AW'(a), '1, {$urandom, $urandom});
         step(1'b1, 1'b0);
      end
      step(1'b1, 1'b0);

      // single m0 read
      arm(0, 1'b0, AW'(10'h010), '1, '0);
      step(1'b1, 1'b0);
      chk("tp_rd_gnt", 64'(m0_gnt_o), 64'd1);
      chk("tp_rd_addr", 64'(mem_addr_o), 64'h010);
      chk("tp_rd_we", 64'(mem_we_o), 64'd0);
      step(1'b1, 1'b0);
      chk("tp_rd_rv0", 64'(m0_rvalid_o), 64'd1);
      chk("tp_rd_rv1", 64'(m1_rvalid_o), 64'd0);
      chk("tp_rd_data", m0_rdata_o, mem_rdata_i);
      step(1'b1, 1'b1);

      // 20 cycles of contention from idle
      for (int i = 0; i < 20; i++) begin
         for (int x = 0; x < 2; x++)
            if (!p_req[x]) arm(x, 1'b0, AW'($urandom_range(0, 31)), '1, '0);
         step(1'b1, 1'b0);
         chk("tp_burst_m1", 64'(m1_gnt_o), 64'((i >= 8) && (i < 16)));
      end
      step(1'b1, 1'b0);
`ifdef SP_MEM_ARB_PERF_EN
      chk("tp_stall_m0", 64'(m0_stall_cnt_o), 64'd8);
      chk("tp_stall_m1", 64'(m1_stall_cnt_o), 64'd12);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("tp_clr_m0", 64'(m0_stall_cnt_o), 64'd0);
      chk("tp_clr_m1", 64'(m1_stall_cnt_o), 64'd0);
`endif
      step(1'b1, 1'b0);

      // m1 partial write with m0 idle
      arm(1, 1'b1, AW'(5), 8'h0F, 64'hDEAD_BEEF_CAFE_F00D);
      step(1'b1, 1'b0);
      chk("tp_wr_we", 64'(mem_we_o), 64'd1);
      chk("tp_wr_be", 64'(mem_be_o), 64'h0F);
      step(1'b1, 1'b0);
      chk("tp_wr_rv", 64'({m0_rvalid_o, m1_rvalid_o}), 64'd0);

      // alternating single reads
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) arm(0, 1'b0, AW'(1), '1, '0);
         else            arm(1, 1'b0, AW'(2), '1, '0);
         step(1'b1, 1'b0);
         chk("tp_il_rv0", 64'(m0_rvalid_o), 64'(i % 2 == 1));
         chk("tp_il_rv1", 64'(m1_rvalid_o), 64'((i > 0) && (i % 2 == 0)));
      end
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);

      // reset right after a granted m1 read
      arm(1, 1'b0, AW'(7), '1, '0);
      step(1'b1, 1'b0);
      arm(0, 1'b0, AW'(3), '1, '0);
      arm(1, 1'b0, AW'(4), '1, '0);
      step(1'b0, 1'b0);
      chk("tp_rst_rv1", 64'(m1_rvalid_o), 64'd0);
      chk("tp_rst_gnt", 64'({m0_gnt_o, m1_gnt_o}), 64'd0);
      step(1'b0, 1'b0);
      chk("tp_rst_idle", 64'(dbg_state_o), 64'(IDLE));
      step(1'b1, 1'b0);

      // random traffic
      for (int n = 0; n < 1500; n++) begin
         for (int x = 0; x < 2; x++)
            if (!p_req[x] && $urandom_range(0, 99) < 55)
               arm(x, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)),
                   BW'($urandom), {$urandom, $urandom});
         step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 99) == 0));
      end
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      repeat (3) step(1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule
